// File: rtl/proc_mem_pkg.sv
// proc_mem_pkg: shared encodings, default widths and the grant tie rule for mem_arbiter.
package proc_mem_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int LINE_W_DEF = 128;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;
    // A lone request wins outright; contention alternates against last_grant.
    function automatic logic next_grant(input logic ic_req, input logic dc_req, input logic last_grant);
        return (ic_req && dc_req) ? ((last_grant == OWN_I) ? OWN_D : OWN_I) : (dc_req ? OWN_D : OWN_I);
    endfunction
endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter timing the fixed memory latency.
module mem_lat_counter #(
    parameter int MEM_LATENCY = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);
    localparam int W = $clog2(MEM_LATENCY + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? W'(MEM_LATENCY - 1) : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-cache and D-cache line accesses onto one fixed-latency memory port.
module mem_arbiter
    import proc_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LINE_W      = LINE_W_DEF,
    parameter int MEM_LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ack,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              stall_fetch,
    output logic              stall_mem
);
    logic [1:0]        state_q, state_d;
    logic              owner_q, last_q, start, gnt, done, fin;
    logic              mem_req_q, mem_we_q, ic_ack_q, dc_ack_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q, ic_rdata_q, dc_rdata_q;
    assign start = (state_q == S_IDLE) && (ic_req || dc_req);
    assign gnt   = next_grant(ic_req, dc_req, last_q);
    assign fin   = (state_q == S_BUSY) && done;
    always_comb state_d = start ? S_BUSY : fin ? S_RESP : (state_q == S_RESP) ? S_IDLE : state_q;
    mem_lat_counter #(.MEM_LATENCY(MEM_LATENCY)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (start),
        .dec_i  (state_q == S_BUSY),
        .done_o (done)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_I;
            last_q      <= OWN_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_ack_q    <= 1'b0;
            dc_ack_q    <= 1'b0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ic_ack_q <= 1'b0;
            dc_ack_q <= 1'b0;
            if (start) begin
                owner_q     <= gnt;
                last_q      <= gnt;
                mem_req_q   <= 1'b1;
                mem_we_q    <= (gnt == OWN_D) && dc_we;
                mem_addr_q  <= (gnt == OWN_D) ? dc_addr : ic_addr;
                mem_wdata_q <= (gnt == OWN_D) ? dc_wdata : '0;
            end
            // Last BUSY cycle: memory data is valid now, hand it to the owner.
            if (fin) begin
                mem_req_q <= 1'b0;
                if (owner_q == OWN_D) begin
                    dc_ack_q   <= 1'b1;
                    dc_rdata_q <= mem_we_q ? '0 : mem_rdata;
                end else begin
                    ic_ack_q   <= 1'b1;
                    ic_rdata_q <= mem_rdata;
                end
            end
        end
    end
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign ic_ack      = ic_ack_q;
    assign dc_ack      = dc_ack_q;
    assign ic_rdata    = ic_rdata_q;
    assign dc_rdata    = dc_rdata_q;
    assign stall_fetch = ic_req & ~ic_ack_q;
    assign stall_mem   = dc_req & ~dc_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-timing model.
module tb_mem_arbiter;
    localparam int L = 5;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic         rst_n = 1'b0;
    logic         ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
    logic [15:0]  ic_addr = '0, dc_addr = '0;
    logic [127:0] dc_wdata = '0, mem_rdata = '0;
    logic         ic_ack, dc_ack, mem_req, mem_we, stall_fetch, stall_mem;
    logic [15:0]  mem_addr;
    logic [127:0] ic_rdata, dc_rdata, mem_wdata;
    logic         b_rst = 1'b0, b_dc_req = 1'b0, b_zero = 1'b0;
    logic [15:0]  b_dc_addr = '0, b_zaddr = '0;
    logic [127:0] b_mem_rdata = '0, b_zline = '0;
    logic         b_ic_ack, b_dc_ack, b_mem_req, b_mem_we, b_sf, b_sm;
    logic [15:0]  b_mem_addr;
    logic [127:0] b_ic_rdata, b_dc_rdata, b_mem_wdata;

    mem_arbiter #(.ADDR_W(16), .LINE_W(128), .MEM_LATENCY(L)) u_dut (
        .clk(clk), .reset(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ack(dc_ack), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_fetch(stall_fetch), .stall_mem(stall_mem)
    );
    mem_arbiter #(.ADDR_W(16), .LINE_W(128), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(b_rst),
        .ic_req(b_zero), .ic_addr(b_zaddr), .ic_ack(b_ic_ack), .ic_rdata(b_ic_rdata),
        .dc_req(b_dc_req), .dc_we(b_zero), .dc_addr(b_dc_addr), .dc_wdata(b_zline),
        .dc_ack(b_dc_ack), .dc_rdata(b_dc_rdata),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .stall_fetch(b_sf), .stall_mem(b_sm)
    );

    int n_chk = 0, n_err = 0;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Model: an access granted at edge g occupies memory after edges g..g+L-1,
    // acks after edge g+L, and the arbiter samples again from edge g+L+2.
    int cyc = 0, g_edge = -100, free_edge = 0;
    logic m_own = 1'b0, m_last = 1'b0, e_we = 1'b0;
    logic [15:0] e_addr = '0;
    logic [127:0] e_wdata = '0, e_ic_rd = '0, e_dc_rd = '0;
    int ic_p = 0, dc_p = 0, we_p = 0;
    bit fix_rd = 0;
    int n_ia = 0, n_da = 0, ia_cyc = 0, da_cyc = 0, n_mreq = 0, n_sf = 0, n_we = 0;
    bit ack_log[$];

    task automatic step();
        logic xr, xi, xd;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            g_edge = -100; free_edge = cyc + 1; m_last = 1'b0;
            e_ic_rd = '0; e_dc_rd = '0; e_addr = '0; e_we = 1'b0; e_wdata = '0;
        end else begin
            if (cyc >= free_edge && (ic_req || dc_req)) begin
                m_own = (ic_req && dc_req) ? ~m_last : dc_req;
                m_last = m_own; g_edge = cyc; free_edge = cyc + L + 2;
                e_addr = m_own ? dc_addr : ic_addr;
                e_we = m_own & dc_we;
                e_wdata = m_own ? dc_wdata : '0;
            end
            if (cyc == g_edge + L) begin
                if (m_own) e_dc_rd = e_we ? '0 : mem_rdata;
                else e_ic_rd = mem_rdata;
            end
        end
        @(negedge clk);
        xr = (cyc >= g_edge) && (cyc < g_edge + L);
        xi = (cyc == g_edge + L) && !m_own;
        xd = (cyc == g_edge + L) && m_own;
        check("mem_req", mem_req, xr);
        check("ic_ack", ic_ack, xi);
        check("dc_ack", dc_ack, xd);
        check("ic_rdata", ic_rdata, e_ic_rd);
        check("dc_rdata", dc_rdata, e_dc_rd);
        check("stall_fetch", stall_fetch, ic_req && !xi);
        check("stall_mem", stall_mem, dc_req && !xd);
        if (xr) begin
            check("mem_addr", mem_addr, e_addr);
            check("mem_we", mem_we, e_we);
            check("mem_wdata", mem_wdata, e_wdata);
        end
        if (mem_req) n_mreq++;
        if (stall_fetch) n_sf++;
        if (mem_req && mem_we) n_we++;
        if (ic_ack) begin n_ia++; ia_cyc = cyc; ack_log.push_back(1'b0); end
        if (dc_ack) begin n_da++; da_cyc = cyc; ack_log.push_back(1'b1); end
        if (ic_ack) ic_req = 1'b0;
        else if (!ic_req && $urandom_range(99) < ic_p) begin ic_req = 1'b1; ic_addr = 16'($urandom); end
        if (dc_ack) dc_req = 1'b0;
        else if (!dc_req && $urandom_range(99) < dc_p) begin
            dc_req = 1'b1; dc_addr = 16'($urandom);
            dc_we = ($urandom_range(99) < we_p);
            dc_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        if (!fix_rd) mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int pres, k, bcnt, back, base;
        bit want_seq[6];
        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_we", mem_we, 0);
        rst_n = 1'b1;
        step();
        // Single instruction fill
        fix_rd = 1; mem_rdata = {16{8'hA5}};
        ic_req = 1'b1; ic_addr = 16'h0040; pres = cyc; n_mreq = 0; n_sf = 0; n_ia = 0;
        #1 check("fill_stall_pres", stall_fetch, 1);
        n_sf = 1;
        repeat (10) step();
        check("fill_mreq_cycles", n_mreq, L);
        check("fill_stall_cycles", n_sf, L + 1);
        check("fill_ack_count", n_ia, 1);
        check("fill_ack_delay", ia_cyc - pres, L + 1);
        check("fill_rdata", ic_rdata, {16{8'hA5}});
        fix_rd = 0;
        // First conflict after reset: D wins, I one IDLE cycle later
        do_reset();
        ic_req = 1'b1; ic_addr = 16'h0100; dc_req = 1'b1; dc_we = 1'b0; dc_addr = 16'h0200;
        dc_wdata = '0; pres = cyc; n_ia = 0; n_da = 0;
        k = 0;
        while (!(n_ia > 0 && n_da > 0) && k < 40) begin step(); k++; end
        check("conflict_done", n_ia > 0 && n_da > 0, 1);
        check("conflict_d_delay", da_cyc - pres, L + 1);
        check("conflict_i_after_d", ia_cyc - da_cyc, L + 2);
        repeat (3) step();
        // Writeback
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 16'h0380;
        dc_wdata = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321; n_we = 0; n_da = 0;
        repeat (10) step();
        check("wb_we_cycles", n_we, L);
        check("wb_ack_count", n_da, 1);
        check("wb_rdata_zero", dc_rdata, 0);
        dc_we = 1'b0;
        // Sustained contention
        do_reset();
        ack_log.delete();
        ic_p = 100; dc_p = 100; we_p = 0;
        k = 0;
        while (ack_log.size() < 6 && k < 200) begin step(); k++; end
        ic_p = 0; dc_p = 0;
        repeat (20) step();
        check("contention_acks", ack_log.size() >= 6, 1);
        want_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6 && i < ack_log.size(); i++) check($sformatf("contention_order%0d", i), ack_log[i], want_seq[i]);
        // Reset during the third BUSY cycle
        base = n_da;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 16'h0440;
        repeat (3) step();
        check("mid_busy", mem_req, 1);
        rst_n = 1'b0; dc_req = 1'b0;
        step();
        check("mid_abort_mreq", mem_req, 0);
        rst_n = 1'b1;
        repeat (8) step();
        check("mid_no_ack", n_da, base);
        dc_req = 1'b1; dc_addr = 16'h0480;
        repeat (10) step();
        check("mid_fresh_ack", n_da, base + 1);
        // Random traffic with occasional resets
        ic_p = 30; dc_p = 30; we_p = 40;
        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(199) != 0);
            step();
        end
        rst_n = 1'b1;
        ic_p = 0; dc_p = 0;
        repeat (20) step();
        // MEM_LATENCY = 1 build
        b_rst = 1'b0;
        @(posedge clk); @(negedge clk);
        b_rst = 1'b1;
        @(posedge clk); @(negedge clk);
        b_dc_req = 1'b1; b_dc_addr = 16'h0500; b_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        bcnt = 0; back = -1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); @(negedge clk);
            if (b_mem_req) begin
                bcnt++;
                check("l1_addr", b_mem_addr, 16'h0500);
            end
            if (b_dc_ack) begin
                back = i; b_dc_req = 1'b0;
                check("l1_rdata", b_dc_rdata, b_mem_rdata);
            end
        end
        check("l1_mreq_cycles", bcnt, 1);
        check("l1_ack_delay", back, 2);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory line port between the fetch-stage instruction-cache miss path and the cache-stage data-cache miss/writeback path.
- Serialises requests and generates the stall levels the processor top uses for fetch's enable_pc and cache_stage's enable_cache.
- Memory has fixed latency; the block counts it and samples the returned line.
- The block sits beside fetch and cache_stage at processor top level.

Parameters:
- ADDR_W, 16, byte address width of requests and memory port.
- LINE_W, 128, cache line width in bits.
- MEM_LATENCY, 5, cycles memory takes from request to valid data; must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- ic_req  in  1  instruction miss request; level, held until ic_ack seen.
- ic_addr  in  ADDR_W  line address for ic_req.
- ic_ack  out  1  one-cycle pulse; ic_rdata valid this cycle.
- ic_rdata  out  LINE_W  returned instruction line.
- dc_req  in  1  data request; level, held until dc_ack seen.
- dc_we  in  1  1 = line writeback, 0 = line fill.
- dc_addr  in  ADDR_W  line address for dc_req.
- dc_wdata  in  LINE_W  writeback data.
- dc_ack  out  1  one-cycle completion pulse.
- dc_rdata  out  LINE_W  returned data line; 0 for writes.
- mem_req  out  1  high for the whole memory access.
- mem_we  out  1  write qualifier.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  LINE_W  write data.
- mem_rdata  in  LINE_W  read data, valid in the last BUSY cycle.
- stall_fetch  out  1  freeze fetch while an instruction request is outstanding.
- stall_mem  out  1  freeze cache stage and older stages while a data request is outstanding.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state = IDLE, cnt = 0, owner = I, last_grant = I.
  - All registered outputs = 0: mem_req, mem_we, mem_addr, mem_wdata, ic_ack, dc_ack, ic_rdata, dc_rdata.
  - Reset mid-access aborts it: no ack is issued and mem_req drops at that edge.
- State machine:
  - IDLE -> BUSY when ic_req or dc_req is sampled high.
  - BUSY -> RESP when cnt == 0.
  - RESP -> IDLE unconditionally.
- Grant rules, applied in IDLE:
  - Only one request high: grant it.
  - Both high: grant D if last_grant == I, else grant I. This alternates under contention; D wins the first conflict after reset.
- On a grant edge:
  - Latch owner, addr, we (forced 0 for I) and wdata.
  - mem_req <= 1, cnt <= MEM_LATENCY-1, last_grant <= owner.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - cnt decrements each cycle.
  - At the edge where cnt == 0: mem_rdata is captured into the owner's rdata (dc_rdata <= 0 if write), the owner's ack <= 1, mem_req <= 0, and state moves to RESP.
- RESP:
  - Exactly one ack is high for one cycle.
  - The next edge clears the ack and returns to IDLE.
- Latency: request first sampled at edge E; ack is high in the cycle after edge E+MEM_LATENCY, i.e. MEM_LATENCY+1 cycles after the request was presented. The minimum gap between two accesses is one IDLE cycle.
- Requester contract: deassert req on the edge after ack is seen. The arbiter never re-samples during RESP, so no duplicate grant occurs.
- Request withdrawn during BUSY: the access still completes and the ack is still pulsed. A requester ignores an ack it no longer wants.
- Stalls are combinational:
  - stall_fetch = ic_req & ~ic_ack.
  - stall_mem = dc_req & ~dc_ack.
  - Both are 0 in the ack cycle, so the pipeline advances exactly once with the data.
- Address and data inputs are don't-care while the matching req is low.

Decomposition:
- Shared package proc_mem_pkg holds:
  - state encoding (IDLE, BUSY, RESP);
  - owner encoding (OWN_I, OWN_D);
  - default LINE_W and ADDR_W constants;
  - the tie rule helper function next_grant(ic_req, dc_req, last_grant).
- One sub-module is natural: mem_lat_counter (load, decrement, done flag, width $clog2(MEM_LATENCY+1)).
- The FSM, latches and ack logic stay in mem_arbiter.

Test Plan:
- Single fill: ic_req=1, ic_addr=16'h0040, mem_rdata=128'hA5… at the last BUSY cycle -> mem_req high 5 cycles, ic_ack pulse 6 cycles after request, ic_rdata = 128'hA5…, stall_fetch high for 6 cycles.
- Simultaneous first conflict: ic_req and dc_req both high in the same cycle after reset -> D served first (mem_addr = dc_addr), I granted after one IDLE cycle; dc_ack precedes ic_ack by 7 cycles.
- Writeback: dc_req=1, dc_we=1, dc_wdata=128'h1234… -> mem_we=1 and mem_wdata stable for all 5 BUSY cycles; dc_ack pulse with dc_rdata = 0.
- Sustained contention: both requesters re-request immediately after each ack for 6 accesses -> grant order D, I, D, I, D, I; no ack duplicated.
- Reset mid-access: reset=0 during the third BUSY cycle -> next cycle mem_req=0, state IDLE, no ack ever issued; a fresh request afterwards completes normally.
- MEM_LATENCY=1 build: a single dc fill -> mem_req high 1 cycle, dc_ack 2 cycles after the request.
